// File: rtl/card_deck_loader.sv
// card_deck_loader
// ----------------
// Writer side of the card memory read by the card-compare logic. A start
// pulse (taken only while idle) builds a deck holding every value
// 0..NUM_CARDS/2-1 exactly twice. The deck is then shuffled in place with a
// Fisher-Yates pass whose draws come from a free-running 16-bit LFSR. The
// shuffled entries are streamed to the memory write port at ascending
// addresses, and a one-cycle done pulse follows the last write.
//
// Ports
//   clock  in   1       system clock, rising edge
//   reset  in   1       synchronous active-high reset
//   start  in   1       request a new deal (sampled only in IDLE)
//   wAddr  out  ADDR_W  card memory write address (0 outside WRITE)
//   wData  out  VAL_W   card value to write (0 outside WRITE)
//   we     out  1       write enable, one write per cycle while high
//   busy   out  1       high while a deal is in progress
//   done   out  1       single-cycle pulse after the last write
//
// All outputs are registered from the current state. The visible write
// burst, done pulse and busy level therefore trail the internal state by
// one cycle. The delay from the start edge to done is
// 1 + NUM_CARDS + shuffle cycles + NUM_CARDS.
module card_deck_loader #(
  parameter int          NUM_CARDS  = 36,
  parameter int          ADDR_W     = 6,
  parameter int          VAL_W      = 5,
  parameter logic [15:0] LFSR_INIT  = 16'hACE1,
  parameter int          MAX_REJECT = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] wAddr,
  output logic [VAL_W-1:0]  wData,
  output logic              we,
  output logic              busy,
  output logic              done
);

  localparam int                REJ_W    = $clog2(MAX_REJECT + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_CARDS - 1);
  localparam logic [ADDR_W-1:0] IDX_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
  localparam logic [REJ_W-1:0]  REJ_ZERO = {REJ_W{1'b0}};
  localparam logic [REJ_W-1:0]  REJ_ONE  = REJ_W'(1);
  localparam logic [REJ_W-1:0]  REJ_LAST = REJ_W'(MAX_REJECT - 1);
  localparam logic [VAL_W-1:0]  VAL_ZERO = {VAL_W{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INIT    = 3'd1,
    ST_SHUFFLE = 3'd2,
    ST_WRITE   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [15:0]         lfsr_r;
  logic [ADDR_W-1:0]   k_r;
  logic [ADDR_W-1:0]   i_r;
  logic [REJ_W-1:0]    rej_r;
  logic [VAL_W-1:0]    deck_r [NUM_CARDS];

  logic [ADDR_W-1:0]   r_s;
  logic [ADDR_W-1:0]   j_s;
  logic                accept_s;
  logic                fallback_s;
  logic                advance_s;

  logic                we_r;
  logic [ADDR_W-1:0]   waddr_r;
  logic [VAL_W-1:0]    wdata_r;
  logic                busy_r;
  logic                done_r;

  // The result is the smallest all-ones value that covers v. It is built
  // by smearing the highest set bit of v into every lower position.
  function automatic logic [ADDR_W-1:0] cover_mask(input logic [ADDR_W-1:0] v);
    logic [ADDR_W-1:0] m;
    m = v;
    for (int b = 1; b < ADDR_W; b++) begin
      m = m | (m >> b);
    end
    return m;
  endfunction

  // Fibonacci LFSR with taps 16,14,13,11. It never pauses outside reset,
  // so the moment the player presses start decides the shuffle.
  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr_r <= LFSR_INIT;
    end else begin
      lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
    end
  end

  // Draw decode. A draw above i is rejected. After MAX_REJECT consecutive
  // rejects, the step is forced through with j = i, so each step ends in
  // bounded time.
  always_comb begin
    r_s        = lfsr_r[ADDR_W-1:0];
    j_s        = r_s & cover_mask(i_r);
    accept_s   = (j_s <= i_r);
    fallback_s = (!accept_s) && (rej_r == REJ_LAST);
    advance_s  = accept_s || fallback_s;
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_INIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_INIT: begin
        if (k_r == LAST_IDX) begin
          state_s = ST_SHUFFLE;
        end else begin
          state_s = ST_INIT;
        end
      end
      ST_SHUFFLE: begin
        // The step at i = 1 is always the last one. Its mask is 1, so that
        // draw can never be rejected.
        if (advance_s && (i_r == IDX_ONE)) begin
          state_s = ST_WRITE;
        end else begin
          state_s = ST_SHUFFLE;
        end
      end
      ST_WRITE: begin
        if (k_r == LAST_IDX) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_WRITE;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Sequencing counters: fill/write index k, shuffle index i, reject count
  always_ff @(posedge clock) begin
    if (reset) begin
      k_r   <= IDX_ZERO;
      i_r   <= IDX_ZERO;
      rej_r <= REJ_ZERO;
    end else begin
      case (state_r)
        ST_INIT: begin
          if (k_r == LAST_IDX) begin
            k_r   <= IDX_ZERO;
            i_r   <= LAST_IDX;
            rej_r <= REJ_ZERO;
          end else begin
            k_r <= k_r + IDX_ONE;
          end
        end
        ST_SHUFFLE: begin
          if (advance_s) begin
            i_r   <= i_r - IDX_ONE;
            rej_r <= REJ_ZERO;
          end else begin
            rej_r <= rej_r + REJ_ONE;
          end
        end
        ST_WRITE: begin
          if (k_r == LAST_IDX) begin
            k_r <= IDX_ZERO;
          end else begin
            k_r <= k_r + IDX_ONE;
          end
        end
        ST_IDLE, ST_DONE: begin
          k_r   <= IDX_ZERO;
          rej_r <= REJ_ZERO;
        end
        default: begin
          k_r   <= IDX_ZERO;
          i_r   <= IDX_ZERO;
          rej_r <= REJ_ZERO;
        end
      endcase
    end
  end

  // Deck storage. INIT fills it with pairs and SHUFFLE swaps entries in
  // place. The contents are don't-care across reset, so they have no reset.
  always_ff @(posedge clock) begin
    if (!reset && (state_r == ST_INIT)) begin
      deck_r[k_r] <= VAL_W'(k_r >> 1);
    end else if (!reset && (state_r == ST_SHUFFLE) && accept_s) begin
      // If j == i, both writes land on the same entry with its own value.
      deck_r[i_r] <= deck_r[j_s];
      deck_r[j_s] <= deck_r[i_r];
    end
  end

  // Registered outputs, derived from the state of the cycle just ending
  always_ff @(posedge clock) begin
    if (reset) begin
      we_r    <= 1'b0;
      waddr_r <= IDX_ZERO;
      wdata_r <= VAL_ZERO;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      busy_r <= (state_r != ST_IDLE);
      done_r <= (state_r == ST_DONE);
      if (state_r == ST_WRITE) begin
        we_r    <= 1'b1;
        waddr_r <= k_r;
        wdata_r <= deck_r[k_r];
      end else begin
        we_r    <= 1'b0;
        waddr_r <= IDX_ZERO;
        wdata_r <= VAL_ZERO;
      end
    end
  end

  assign wAddr = waddr_r;
  assign wData = wdata_r;
  assign we    = we_r;
  assign busy  = busy_r;
  assign done  = done_r;

endmodule

// File: tb/tb_card_deck_loader.sv
// Testbench for card_deck_loader.
// A posedge model process runs its own copy of the LFSR. When the model
// sees start accepted in IDLE, it computes the whole shuffle and queues
// every expected write, each with its cycle number, plus the expected done
// cycle. A negedge monitor pops and compares whatever the DUT presents.
module tb_card_deck_loader;

  localparam int N = 36;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [5:0] wAddr;
  logic [4:0] wData;
  logic       we;
  logic       busy;
  logic       done;

  card_deck_loader dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .wAddr (wAddr),
    .wData (wData),
    .we    (we),
    .busy  (busy),
    .done  (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         cyc;
    logic [5:0] addr;
    logic [4:0] data;
  } wr_t;

  int          checks     = 0;
  int          failures   = 0;
  int          cyc        = 0;
  logic [15:0] m_lfsr     = 16'h0000;
  int          busy_left  = 0;
  logic        m_nonidle  = 1'b0;
  logic        exp_busy   = 1'b0;
  int          deals_done = 0;
  int          wr_count   = 0;
  int          val_cnt [32];
  logic        prev_we    = 1'b0;
  logic [5:0]  prev_addr  = 6'd0;
  int          last_s     = 0;
  wr_t         wr_q [$];
  int          done_q [$];
  wr_t         mon_w;
  int          mon_d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] lstep(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Reference deal: l0 is the LFSR value in the first INIT cycle and e is
  // the edge that accepted start.
  task automatic model_deal(input logic [15:0] l0, input int e, output int s);
    int          deck [N];
    logic [15:0] l;
    int          i, rej, j, m, t;
    wr_t         w;
    for (int k = 0; k < N; k++) deck[k] = k / 2;
    l = l0;
    repeat (N) l = lstep(l);
    i = N - 1; rej = 0; s = 0;
    while (i >= 1) begin
      m = 1;
      while (m < i) m = m * 2 + 1;
      j = int'(l[5:0]) & m;
      s++;
      if (j <= i) begin
        t = deck[i]; deck[i] = deck[j]; deck[j] = t;
        i--; rej = 0;
      end else begin
        rej++;
        if (rej == 16) begin
          i--; rej = 0;
        end
      end
      l = lstep(l);
    end
    checks++;
    if (s > 560) begin
      failures++;
      $display("FAIL shuffle_len: got %0d, expected <= 560", s);
    end
    for (int k = 0; k < N; k++) begin
      w.cyc  = e + N + 1 + s + k;
      w.addr = 6'(k);
      w.data = 5'(deck[k]);
      wr_q.push_back(w);
    end
    done_q.push_back(e + 2 * N + 1 + s);
  endtask

  // Model: cycle count, LFSR, idle tracking and expected-response generation
  always @(posedge clock) begin
    cyc = cyc + 1;
    if (reset) begin
      m_lfsr    = 16'hACE1;
      busy_left = 0;
      m_nonidle = 1'b0;
      exp_busy  = 1'b0;
      wr_q.delete();
      done_q.delete();
    end else begin
      exp_busy = m_nonidle;
      if (busy_left == 0 && start) begin
        model_deal(lstep(m_lfsr), cyc, last_s);
        busy_left = 2 * N + 1 + last_s;
      end else if (busy_left > 0) begin
        busy_left = busy_left - 1;
      end
      m_nonidle = (busy_left > 0);
      m_lfsr    = lstep(m_lfsr);
    end
  end

  // Monitor: compare DUT outputs against the queued expectations
  always @(negedge clock) begin
    if (reset) begin
      wr_count = 0;
      for (int v = 0; v < 32; v++) val_cnt[v] = 0;
      prev_we   = 1'b0;
      prev_addr = 6'd0;
    end else begin
      check("busy", busy, exp_busy);
      while (wr_q.size() > 0 && wr_q[0].cyc < cyc) begin
        mon_w = wr_q.pop_front();
        checks++; failures++;
        $display("FAIL missing_write: addr %0d not seen at cycle %0d", mon_w.addr, mon_w.cyc);
      end
      if (we) begin
        if (wr_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_write: addr %0d data %0d at cycle %0d", wAddr, wData, cyc);
        end else begin
          mon_w = wr_q.pop_front();
          check("write_cycle", cyc, mon_w.cyc);
          check("waddr", wAddr, mon_w.addr);
          check("wdata", wData, mon_w.data);
        end
        check("wdata_range", (wData <= 5'd17), 1'b1);
        val_cnt[wData]++;
        wr_count++;
      end else begin
        check("idle_waddr", wAddr, 6'd0);
        check("idle_wdata", wData, 5'd0);
      end
      if (done) begin
        if (done_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
        end else begin
          mon_d = done_q.pop_front();
          check("done_cycle", cyc, mon_d);
        end
        check("done_after_last", {prev_we, prev_addr}, {1'b1, 6'd35});
        check("write_count", wr_count, N);
        for (int v = 0; v < N / 2; v++) check("pair_count", val_cnt[v], 2);
        for (int v = 0; v < 32; v++) val_cnt[v] = 0;
        wr_count = 0;
        deals_done++;
      end else if (done_q.size() > 0 && done_q[0] <= cyc) begin
        mon_d = done_q.pop_front();
        checks++; failures++;
        $display("FAIL missing_done: got 0, expected done at cycle %0d", mon_d);
      end
      prev_we   = we;
      prev_addr = wAddr;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (done !== 1'b1 && n < budget);
    check("done_seen", done, 1'b1);
  endtask

  task automatic wait_write_addr(input logic [5:0] a, input int budget);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(we === 1'b1 && wAddr === a) && n < budget);
    check("write_seen", {we, wAddr}, {1'b1, a});
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_we", we, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_waddr", wAddr, 6'd0);
    check("rst_wdata", wData, 5'd0);
    check("rst_lfsr", dut.lfsr_r, 16'hACE1);

    // Single deal started 5 cycles after reset
    repeat (5) @(negedge clock);
    pulse_start();
    wait_done(1200);

    // start pulses during INIT, SHUFFLE and WRITE must be ignored
    repeat (4) @(negedge clock);
    pulse_start();
    repeat (10) @(negedge clock);
    pulse_start();
    repeat (40) @(negedge clock);
    pulse_start();
    wait_write_addr(6'd3, 1200);
    pulse_start();
    wait_done(1200);

    // Reset in the middle of the write burst
    repeat (3) @(negedge clock);
    pulse_start();
    wait_write_addr(6'd20, 1200);
    reset = 1'b1;
    @(negedge clock);
    check("abort_we", we, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    repeat (80) @(negedge clock);
    pulse_start();
    wait_done(1200);

    // start held high: two back-to-back deals
    repeat (3) @(negedge clock);
    start = 1'b1;
    wait_done(1200);
    wait_done(1200);
    start = 1'b0;

    repeat (5) @(negedge clock);
    check("pending_writes", wr_q.size(), 0);
    check("pending_dones", done_q.size(), 0);
    check("deals_done", deals_done, 5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
